board_redraw_scheduler: RTL and testbench
=========================================

# board_redraw_scheduler

Sequencer and arbiter for the 32×20-bit block-table RAM and the VGA pixel port. On a redraw request it optionally clears the board square, then walks the block table one entry at a time and rasterises each valid block as a rectangle, one pixel per clock. It also shares the single RAM port between the redraw walker and the move FSM's table-update writes.

## Interface
Parameters:
- NUM_BLOCKS, 16: table entries walked, addresses 0..NUM_BLOCKS-1 (≤32).
- LEN_PX, 16: block long-side length in pixels.
- WID_PX, 4: block short-side length in pixels.
- BOARD_X0, 49 and BOARD_Y0, 49: top-left corner of the clear square.
- BOARD_SIZE, 32: side length of the clear square.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous, active-high.
- start  in  1  redraw request pulse.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a redraw.
- upd_req  in  1  move FSM write request, held until ack.
- upd_addr  in  5  table address to write.
- upd_data  in  20  record to write.
- upd_ack  out  1  one-cycle pulse; the write occurs in this cycle.
- mem_addr  out  5  RAM address.
- mem_wdata  out  20  RAM write data.
- mem_wren  out  1  RAM write enable.
- mem_rdata  in  20  RAM q: address registered, output unregistered, valid the cycle after the address is presented.
- x  out  8, y  out  7, colour  out  3, plot  out  1  registered pixel port to the VGA adapter.

## Operation
- Record format: [7:0] x, [14:8] y, [15] orient (0 = horizontal), [18:16] colour, [19] valid.
- States are IDLE, CLEAR, FETCH, LATCH, DRAW, NEXT and DONE.
- **IDLE**
  - If upd_req is high, drive mem_wren=1, mem_addr=upd_addr, mem_wdata=upd_data and upd_ack=1 for one cycle. Stay in IDLE.
  - Otherwise, if start or the pending flag is set, clear pending and go to CLEAR. With BOARD_CLEAR_EN undefined, go to FETCH instead. The entry index is reset to 0.
- **start while not IDLE**: sets a sticky pending flag; a second redraw follows DONE.
- **start together with upd_req in IDLE**: the write wins and pending is set.
- **upd_req while busy**: no ack. The request stalls until the FSM returns to IDLE.
- **CLEAR**
  - Emits BOARD_SIZE² pixels in raster order, x fastest, from (BOARD_X0, BOARD_Y0).
  - colour=0, one pixel per cycle, then go to FETCH.
- **FETCH**: mem_addr=index, mem_wren=0, one cycle.
- **LATCH**
  - Capture mem_rdata into the block register.
  - If valid=0, go to NEXT. Otherwise go to DRAW.
- **DRAW**
  - Emits LEN_PX×WID_PX pixels with colour=record colour, one per cycle.
  - Offset counter: long-axis index i in 0..LEN_PX-1, short-axis index j in 0..WID_PX-1, j fastest.
  - Horizontal block: x=bx+i, y=by+j. Vertical block: x=bx+j, y=by+i.
- **Pixel arithmetic**: x is computed modulo 256 and y modulo 128. Pixels with x>159 or y>119 use their cycle but are emitted with plot=0.
- **NEXT**: if index==NUM_BLOCKS-1, go to DONE. Otherwise increment index and go to FETCH.
- **DONE**: done=1 for one cycle, then go to IDLE.

## Timing
- **Reset values**: state=IDLE, pending=0, plot=0, x=0, y=0, colour=0, done=0, upd_ack=0, mem_wren=0, mem_addr=0, mem_wdata=0, busy=0.
- **Reset mid-operation**: abort at the next edge. plot=0 from the following cycle. Pending is lost and no RAM write is issued.
- **Pixel latency**: x/y/colour/plot are registered, so a pixel appears one cycle after the state/counter cycle that generates it. The done pulse follows the last pixel.
- **Redraw length in cycles**, from the start edge to the done pulse:
  - (BOARD_SIZE² if BOARD_CLEAR_EN)
  - plus 3 per valid entry plus LEN_PX×WID_PX
  - plus 3 per invalid entry
  - plus 1.
- **Outside CLEAR/DRAW**: plot=0. mem_wren=1 only on upd_ack cycles.

## Configuration
- BOARD_CLEAR_EN defined: the CLEAR phase precedes the block walk.
- BOARD_CLEAR_EN undefined: the CLEAR state and its counter are removed, and start goes straight to FETCH. Used for incremental overdraw.

## Structure
- Package unblock_pkg holds:
  - record field offsets and widths, plus a block record typedef;
  - the state enum;
  - BOARD_X0/Y0/SIZE and screen limits 160×120.
- Sub-module rect_pixel_walker is a loadable 2-D counter (inner/outer limits, last flag) shared by CLEAR and DRAW.

## Test plan
- **Horizontal block**: entry 0 = {valid, colour 3'b100, orient 0, y 60, x 50}, other entries invalid, clear disabled, start → 64 plots covering x 50..65, y 60..63, colour 4. done pulses exactly 1+3+64+3×15+1 = 114 cycles after start.
- **Vertical block**: same entry with orient=1 → 64 plots covering x 50..53, y 60..75.
- **Clear phase**: clear enabled, empty table → 1024 plots with colour 0 from (49,49) to (80,80) in raster order, then done.
- **Arbitration**
  - upd_req raised mid-redraw → no upd_ack until IDLE, then exactly one write cycle with the correct addr/data.
  - start and upd_req together in IDLE → write first, then redraw, and the fetched data reflects the new record.
- **Clipping**: entry x=150, horizontal → plot=0 for x 160..165 while pixels with x 150..159 are plotted.
- **Reset**: asserted during DRAW → plot=0 and busy=0 on the next cycle. A new start then redraws from index 0.

Source files
------------

// File: rtl/board_redraw_scheduler_pkg.sv
// Shared types for the board redraw scheduler: block record layout, FSM states, board geometry.
package unblock_pkg;

  localparam int REC_W      = 20;
  localparam int X_LSB      = 0;
  localparam int X_W        = 8;
  localparam int Y_LSB      = 8;
  localparam int Y_W        = 7;
  localparam int ORIENT_BIT = 15;
  localparam int COL_LSB    = 16;
  localparam int COL_W      = 3;
  localparam int VALID_BIT  = 19;

  typedef struct packed {
    logic             valid;
    logic [COL_W-1:0] colour;
    logic             orient;
    logic [Y_W-1:0]   y;
    logic [X_W-1:0]   x;
  } block_rec_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_LATCH,
    S_DRAW,
    S_NEXT,
    S_DONE
  } state_t;

  localparam int DEF_BOARD_X0   = 49;
  localparam int DEF_BOARD_Y0   = 49;
  localparam int DEF_BOARD_SIZE = 32;
  localparam int SCREEN_W       = 160;
  localparam int SCREEN_H       = 120;

  localparam int WALK_W = 8;

endpackage

// File: rtl/board_redraw_scheduler_walker.sv
// Loadable 2-D pixel counter: inner index runs fastest, wraps into outer; last flags the final pixel.
module rect_pixel_walker
  import unblock_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [WALK_W-1:0] inner_max,
  input  logic [WALK_W-1:0] outer_max,
  output logic [WALK_W-1:0] inner,
  output logic [WALK_W-1:0] outer,
  output logic              last
);

  logic [WALK_W-1:0] inner_lim;
  logic [WALK_W-1:0] outer_lim;

  always_ff @(posedge clk) begin
    if (reset) begin
      inner     <= '0;
      outer     <= '0;
      inner_lim <= '0;
      outer_lim <= '0;
    end else if (load) begin
      inner     <= '0;
      outer     <= '0;
      inner_lim <= inner_max;
      outer_lim <= outer_max;
    end else if (step) begin
      if (inner == inner_lim) begin
        inner <= '0;
        outer <= outer + 1'b1;
      end else begin
        inner <= inner + 1'b1;
      end
    end
  end

  assign last = (inner == inner_lim) && (outer == outer_lim);

endmodule

// File: rtl/board_redraw_scheduler.sv
// Redraw sequencer and block-table RAM arbiter feeding the VGA pixel port.
// BOARD_CLEAR_EN: when defined, a board-clear raster precedes the block walk.
module board_redraw_scheduler
  import unblock_pkg::*;
#(
  parameter int NUM_BLOCKS = 16,
  parameter int LEN_PX     = 16,
  parameter int WID_PX     = 4,
  parameter int BOARD_X0   = DEF_BOARD_X0,
  parameter int BOARD_Y0   = DEF_BOARD_Y0,
  parameter int BOARD_SIZE = DEF_BOARD_SIZE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic        upd_req,
  input  logic [4:0]  upd_addr,
  input  logic [19:0] upd_data,
  output logic        upd_ack,
  output logic [4:0]  mem_addr,
  output logic [19:0] mem_wdata,
  output logic        mem_wren,
  input  logic [19:0] mem_rdata,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot
);

  localparam logic [WALK_W-1:0] CLEAR_MAX = WALK_W'(BOARD_SIZE - 1);
  localparam logic [WALK_W-1:0] WID_MAX   = WALK_W'(WID_PX - 1);
  localparam logic [WALK_W-1:0] LEN_MAX   = WALK_W'(LEN_PX - 1);
  localparam logic [4:0]        LAST_IDX  = 5'(NUM_BLOCKS - 1);

  state_t      state, state_nxt;
  logic        pending, pending_nxt;
  logic [4:0]  index, index_nxt;
  block_rec_t  rec;
  logic [7:0]  bx;
  logic [6:0]  by;
  logic        borient;
  logic [2:0]  bcolour;

  logic              wk_load, wk_step, wk_last;
  logic [WALK_W-1:0] wk_inner, wk_outer, wk_inner_max, wk_outer_max;

  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic [2:0] pix_colour;
  logic       pix_draw, pix_on;

  assign rec     = mem_rdata;
  assign busy    = (state != S_IDLE);
  assign wk_step = (state == S_CLEAR) || (state == S_DRAW);

  // Only IDLE loads the clear raster; LATCH loads the block rectangle.
  assign wk_inner_max = (state == S_IDLE) ? CLEAR_MAX : WID_MAX;
  assign wk_outer_max = (state == S_IDLE) ? CLEAR_MAX : LEN_MAX;

  rect_pixel_walker u_walker (
    .clk       (clk),
    .reset     (reset),
    .load      (wk_load),
    .step      (wk_step),
    .inner_max (wk_inner_max),
    .outer_max (wk_outer_max),
    .inner     (wk_inner),
    .outer     (wk_outer),
    .last      (wk_last)
  );

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    index_nxt   = index;
    wk_load     = 1'b0;
    upd_ack     = 1'b0;
    mem_wren    = 1'b0;
    mem_addr    = index;
    mem_wdata   = '0;

    if (start && ((state != S_IDLE) || upd_req)) pending_nxt = 1'b1;

    case (state)
      S_IDLE: begin
        // Table writes win over a redraw; the redraw request is remembered.
        if (upd_req && !reset) begin
          upd_ack   = 1'b1;
          mem_wren  = 1'b1;
          mem_addr  = upd_addr;
          mem_wdata = upd_data;
        end else if (start || pending) begin
          pending_nxt = 1'b0;
          index_nxt   = '0;
`ifdef BOARD_CLEAR_EN
          state_nxt   = S_CLEAR;
          wk_load     = 1'b1;
`else
          state_nxt   = S_FETCH;
`endif
        end
      end
      S_CLEAR: if (wk_last) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_LATCH;
      S_LATCH: begin
        if (rec.valid) begin
          state_nxt = S_DRAW;
          wk_load   = 1'b1;
        end else begin
          state_nxt = S_NEXT;
        end
      end
      S_DRAW: if (wk_last) state_nxt = S_NEXT;
      S_NEXT: begin
        if (index == LAST_IDX) begin
          state_nxt = S_DONE;
        end else begin
          index_nxt = index + 5'd1;
          state_nxt = S_FETCH;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pix_x      = '0;
    pix_y      = '0;
    pix_colour = '0;
    pix_draw   = 1'b0;
    case (state)
      S_CLEAR: begin
        pix_x    = 8'(BOARD_X0) + wk_inner;
        pix_y    = 7'(8'(BOARD_Y0) + wk_outer);
        pix_draw = 1'b1;
      end
      S_DRAW: begin
        // Outer counter walks the long side, so its axis follows orientation.
        if (!borient) begin
          pix_x = bx + wk_outer;
          pix_y = 7'({1'b0, by} + wk_inner);
        end else begin
          pix_x = bx + wk_inner;
          pix_y = 7'({1'b0, by} + wk_outer);
        end
        pix_colour = bcolour;
        pix_draw   = 1'b1;
      end
      default: ;
    endcase
  end

  assign pix_on = pix_draw && (pix_x < 8'(SCREEN_W)) && (pix_y < 7'(SCREEN_H));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      pending <= 1'b0;
      index   <= '0;
      bx      <= '0;
      by      <= '0;
      borient <= 1'b0;
      bcolour <= '0;
      x       <= '0;
      y       <= '0;
      colour  <= '0;
      plot    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      index   <= index_nxt;
      if (state == S_LATCH) begin
        bx      <= rec.x;
        by      <= rec.y;
        borient <= rec.orient;
        bcolour <= rec.colour;
      end
      x      <= pix_x;
      y      <= pix_y;
      colour <= pix_colour;
      plot   <= pix_on;
      done   <= (state == S_DONE);
    end
  end

endmodule

// File: tb/tb_board_redraw_scheduler.sv
// Self-checking bench: table-driven block vectors, arbitration/reset sequences, random tables vs pixel-list model.
module tb_board_redraw_scheduler;

  localparam int NB = 16, LEN = 16, WID = 4, X0 = 49, Y0 = 49, SZ = 32;
  localparam int BUDGET = 5000;
`ifdef BOARD_CLEAR_EN
  localparam int CLR_CYC = SZ * SZ;
`else
  localparam int CLR_CYC = 0;
`endif

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, upd_req = 1'b0;
  logic [4:0]  upd_addr = '0;
  logic [19:0] upd_data = '0;
  logic        busy, done, upd_ack, mem_wren, plot;
  logic [4:0]  mem_addr;
  logic [19:0] mem_wdata, mem_rdata;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;

  always #5 clk = ~clk;

  board_redraw_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .upd_req(upd_req), .upd_addr(upd_addr), .upd_data(upd_data), .upd_ack(upd_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rdata(mem_rdata),
    .x(x), .y(y), .colour(colour), .plot(plot)
  );

  // RAM: registered address, unregistered output.
  logic [19:0] ram [32];
  logic [4:0]  ram_addr_q;
  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr] <= mem_wdata;
    ram_addr_q <= mem_addr;
  end
  assign mem_rdata = ram[ram_addr_q];

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  typedef struct {
    logic [19:0] rec;
    int cnt, xmin, xmax, ymin, ymax, lat;
  } vec_t;

  pix_t        obs_q[$];
  pix_t        exp_q[$];
  int          exp_lat;
  logic [19:0] shadow [NB];
  int          checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, expv);
    end
  endtask

  // Per-cycle port rules plus pixel capture.
  always @(negedge clk) begin
    pix_t p;
    #3;
    if (!reset) begin
      checks++;
      if ((mem_wren !== upd_ack) || (upd_ack && busy) || (plot && !busy)) begin
        errors++;
        if (errors < 20)
          $display("FAIL port_rules t=%0t wren=%b ack=%b busy=%b plot=%b", $time, mem_wren, upd_ack, busy, plot);
      end
    end
    if (plot === 1'b1) begin
      p.x = x; p.y = y; p.c = colour;
      obs_q.push_back(p);
    end
  end

  function automatic void add_pix(input int px, input int py, input int pc);
    pix_t p;
    if (px < 160 && py < 120) begin
      p.x = 8'(px); p.y = 7'(py); p.c = 3'(pc);
      exp_q.push_back(p);
    end
  endfunction

  // Expected pixel stream and start-to-done latency from the shadow table.
  function automatic void build_model();
    logic [19:0] r;
    int bxv, byv, px, py;
    exp_q.delete();
    exp_lat = 2 + CLR_CYC;
`ifdef BOARD_CLEAR_EN
    for (int row = 0; row < SZ; row++)
      for (int col = 0; col < SZ; col++) add_pix(X0 + col, Y0 + row, 0);
`endif
    for (int e = 0; e < NB; e++) begin
      r = shadow[e];
      exp_lat += 3;
      if (r[19]) begin
        exp_lat += LEN * WID;
        bxv = int'(r[7:0]);
        byv = int'(r[14:8]);
        for (int i = 0; i < LEN; i++)
          for (int j = 0; j < WID; j++) begin
            px = (bxv + (r[15] ? j : i)) % 256;
            py = (byv + (r[15] ? i : j)) % 128;
            add_pix(px, py, int'(r[18:16]));
          end
      end
    end
  endfunction

  task automatic compare_pix(input string nm);
    int bad;
    bad = -1;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_pixcount actual=%0d expected=%0d", nm, obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) if (bad < 0 && obs_q[i] !== exp_q[i]) bad = i;
      if (bad >= 0) begin
        errors++;
        $display("FAIL %s_pixel idx=%0d actual=(%0d,%0d,%0d) expected=(%0d,%0d,%0d)", nm, bad,
                 obs_q[bad].x, obs_q[bad].y, obs_q[bad].c, exp_q[bad].x, exp_q[bad].y, exp_q[bad].c);
      end
    end
  endtask

  task automatic write_entry(input logic [4:0] a, input logic [19:0] d);
    int n;
    n = 0;
    @(negedge clk);
    upd_req = 1'b1; upd_addr = a; upd_data = d;
    #1;
    while (!upd_ack && n < BUDGET) begin
      @(negedge clk); #1; n++;
    end
    if (!upd_ack) chk("write_ack_timeout", 0, 1);
    @(posedge clk); #1;
    upd_req = 1'b0;
    if (a < NB) shadow[a] = d;
  endtask

  // Counts negedges after the start-sampling edge until done is seen.
  task automatic wait_done(output int k);
    k = 0;
    do begin
      @(negedge clk); k++;
    end while (!done && k < BUDGET);
  endtask

  task automatic run_redraw(input string nm, output int k);
    build_model();
    obs_q.delete();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(k);
    chk({nm, "_latency"}, k, exp_lat);
    @(negedge clk); #4;
    compare_pix(nm);
  endtask

  vec_t vt [6];
  localparam logic [19:0] HREC = {1'b1, 3'd4, 1'b0, 7'd60, 8'd50};

  initial begin
    int k, cnt, xmn, xmx, ymn, ymx, badc, n;
    logic [19:0] d;
    logic stayed;

    vt[0] = '{rec: HREC,                                  cnt: 64, xmin: 50,  xmax: 65,  ymin: 60,  ymax: 63,  lat: 114};
    vt[1] = '{rec: {1'b1, 3'd4, 1'b1, 7'd60,  8'd50},     cnt: 64, xmin: 50,  xmax: 53,  ymin: 60,  ymax: 75,  lat: 114};
    vt[2] = '{rec: {1'b1, 3'd5, 1'b0, 7'd60,  8'd150},    cnt: 40, xmin: 150, xmax: 159, ymin: 60,  ymax: 63,  lat: 114};
    vt[3] = '{rec: {1'b1, 3'd6, 1'b0, 7'd10,  8'd250},    cnt: 40, xmin: 0,   xmax: 9,   ymin: 10,  ymax: 13,  lat: 114};
    vt[4] = '{rec: {1'b0, 3'd7, 1'b0, 7'd60,  8'd50},     cnt: 0,  xmin: 255, xmax: 0,   ymin: 127, ymax: 0,   lat: 50};
    vt[5] = '{rec: {1'b1, 3'd1, 1'b1, 7'd110, 8'd20},     cnt: 40, xmin: 20,  xmax: 23,  ymin: 110, ymax: 119, lat: 114};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);   chk("rst_plot", plot, 0);
    chk("rst_x", x, 0);         chk("rst_y", y, 0);         chk("rst_colour", colour, 0);
    chk("rst_ack", upd_ack, 0); chk("rst_wren", mem_wren, 0);
    chk("rst_addr", mem_addr, 0); chk("rst_wdata", mem_wdata, 0);
    reset = 1'b0;

    for (int a = 0; a < NB; a++) write_entry(5'(a), 20'd0);

    // Table-driven single-block vectors in entry 0
    for (int v = 0; v < 6; v++) begin
      write_entry(5'd0, vt[v].rec);
      run_redraw($sformatf("vec%0d", v), k);
      chk($sformatf("vec%0d_lat_const", v), k, vt[v].lat + CLR_CYC);
      cnt = 0; xmn = 255; xmx = 0; ymn = 127; ymx = 0; badc = 0;
      foreach (obs_q[i]) if (obs_q[i].c != 3'd0) begin
        cnt++;
        if (obs_q[i].c != vt[v].rec[18:16]) badc++;
        if (int'(obs_q[i].x) < xmn) xmn = int'(obs_q[i].x);
        if (int'(obs_q[i].x) > xmx) xmx = int'(obs_q[i].x);
        if (int'(obs_q[i].y) < ymn) ymn = int'(obs_q[i].y);
        if (int'(obs_q[i].y) > ymx) ymx = int'(obs_q[i].y);
      end
      chk($sformatf("vec%0d_count", v), cnt, vt[v].cnt);
      chk($sformatf("vec%0d_xmin", v), xmn, vt[v].xmin);
      chk($sformatf("vec%0d_xmax", v), xmx, vt[v].xmax);
      chk($sformatf("vec%0d_ymin", v), ymn, vt[v].ymin);
      chk($sformatf("vec%0d_ymax", v), ymx, vt[v].ymax);
      chk($sformatf("vec%0d_colour", v), badc, 0);
    end

`ifdef BOARD_CLEAR_EN
    write_entry(5'd0, 20'd0);
    run_redraw("clear", k);
    chk("clear_count", obs_q.size(), SZ * SZ);
    if (obs_q.size() > 0) begin
      chk("clear_first", obs_q[0], {8'd49, 7'd49, 3'd0});
      chk("clear_last", obs_q[obs_q.size()-1], {8'd80, 7'd80, 3'd0});
    end
`endif

    // Write request arriving mid-redraw waits for IDLE
    write_entry(5'd0, HREC);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(negedge clk);
    d = {1'b1, 3'd2, 1'b1, 7'd20, 8'd100};
    upd_req = 1'b1; upd_addr = 5'd5; upd_data = d;
    n = 0; #1;
    while (!upd_ack && n < BUDGET) begin
      @(negedge clk); #1; n++;
    end
    chk("arb_ack_seen", upd_ack, 1);
    chk("arb_ack_at_done", done, 1);
    chk("arb_wait", (n > 50), 1);
    chk("arb_addr", mem_addr, 5);
    chk("arb_wdata", mem_wdata, d);
    chk("arb_wren", mem_wren, 1);
    @(posedge clk); #1; upd_req = 1'b0; shadow[5] = d;
    run_redraw("arb_after", k);

    // start and upd_req together: write first, then redraw sees the new record
    write_entry(5'd5, 20'd0);
    write_entry(5'd0, 20'd0);
    d = {1'b1, 3'd3, 1'b0, 7'd30, 8'd70};
    @(negedge clk);
    start = 1'b1; upd_req = 1'b1; upd_addr = 5'd0; upd_data = d;
    #1;
    chk("both_ack", upd_ack, 1);
    chk("both_busy", busy, 0);
    @(posedge clk); #1;
    start = 1'b0; upd_req = 1'b0; shadow[0] = d;
    build_model(); obs_q.delete();
    wait_done(k);
    chk("both_latency", k, exp_lat + 1);
    @(negedge clk); #4;
    compare_pix("both");

    // start while busy queues exactly one follow-on redraw
    build_model(); obs_q.delete();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(k);
    wait_done(k);
    chk("pending_gap", k, exp_lat);
    @(negedge clk); #4;
    chk("pending_pixels", obs_q.size(), 2 * exp_q.size());
    repeat (5) @(negedge clk);
    chk("pending_single", busy, 0);

    // Reset during DRAW aborts and loses pending
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    k = 0;
    while (plot !== 1'b1 && k < BUDGET) begin
      @(negedge clk); #4; k++;
    end
    chk("rst_mid_drawing", plot, 1);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1;
    chk("rst_mid_plot", plot, 0);
    chk("rst_mid_busy", busy, 0);
    reset = 1'b0;
    stayed = 1'b1;
    repeat (6) begin
      @(negedge clk); #1;
      if (busy !== 1'b0) stayed = 1'b0;
    end
    chk("rst_pending_lost", stayed, 1);
    run_redraw("rst_redraw", k);

    // Random tables against the pixel-list model
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < NB; a++) begin
        d = 20'($urandom);
        d[19] = ($urandom_range(0, 2) != 0);
        write_entry(5'(a), d);
      end
      run_redraw($sformatf("rand%0d", r), k);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
